ivector_relay: RTL and testbench
================================

Name: ivector_relay

Overview:
- Parametrised successor of the single-entry say→heard relay.
- Accepts `say(meth, v)` requests on an ENA/RDY method port and buffers them in a DEPTH-entry circular FIFO.
- A `respond` rule, gated by the scheduler's `rule_enable`, dequeues the head and fires `ind_heard(meth, v)` toward the indication consumer.
- Adds configurable widths and depth, occupancy/high-water reporting, and a delivered-message counter; sits between the request decoder and the indication proxy.

Parameters:
- METH_W, 32, width of `meth` field
- V_W, 32, width of `v` field
- DEPTH, 4, FIFO entries; power of two, >= 2
- HIWAT, 3, occupancy at or above which `hiwat` asserts; 1..DEPTH
- (localparam) CNT_W = clog2(DEPTH)+1, occupancy width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- say__ENA  in  1  enqueue request
- say_meth  in  METH_W  request method id
- say_v  in  V_W  request value
- say__RDY  out  1  FIFO can accept
- ind_heard__ENA  out  1  indication fired this cycle
- ind_heard_meth  out  METH_W  head meth
- ind_heard_v  out  V_W  head v
- ind_heard__RDY  in  1  consumer can accept
- rule_enable  in  1  scheduler enable for `respond` rule
- rule_ready  out  1  `respond` rule could fire
- occupancy  out  CNT_W  entries held, 0..DEPTH
- hiwat  out  1  occupancy >= HIWAT (registered)
- heard_count  out  32  indications delivered, saturating

Behaviour:
- Reset (RST=1 at posedge): rd_ptr=wr_ptr=0; occupancy=0; hiwat=0; heard_count=0.
  - Consequently say__RDY=1, rule_ready=0, ind_heard__ENA=0.
  - Storage array is not cleared; ind_heard_meth/ind_heard_v are don't-care while empty.
- say__RDY = (occupancy != DEPTH); purely registered-state derived, no dependence on the same-cycle dequeue.
- Enqueue: enq = say__ENA & say__RDY.
  - On enq, mem[wr_ptr] <= {say_meth, say_v}; wr_ptr increments modulo DEPTH.
  - say__ENA while !say__RDY is ignored: no state change, and the bench flags it as a protocol error.
- rule_ready = (occupancy != 0) & ind_heard__RDY.
- Dequeue: deq = rule_enable & rule_ready.
  - ind_heard__ENA = deq.
  - {ind_heard_meth, ind_heard_v} = mem[rd_ptr], combinational from registered head.
  - On deq, rd_ptr increments modulo DEPTH.
- Occupancy: enq&!deq → +1; deq&!enq → -1; both or neither → unchanged.
- Simultaneous enq and deq:
  - Legal at any occupancy where each is individually allowed.
  - When full, enq is blocked even if deq fires the same cycle (no pass-through on full).
  - When empty, deq cannot fire; the new word is visible next cycle.
- Latency: word accepted at edge t is presented with ind_heard__ENA possible in cycle t+1 (1-cycle minimum); FIFO order is strict.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally; full/empty are distinguished by occupancy, not by pointer compare.
- hiwat: registered, updated each cycle from next-state occupancy, so it equals (occupancy >= HIWAT) in the same cycle as occupancy.
- heard_count: +1 per deq; saturates at 32'hFFFF_FFFF, no wrap.
- Reset mid-operation: all in-flight entries are discarded; first post-reset say is the first delivered; heard_count returns to 0.

Optional Feature:
- Macro: IVECTOR_RELAY_BYPASS_EN.
- With it defined, when occupancy==0 and say__ENA & rule_enable & ind_heard__RDY in the same cycle:
  - The request is forwarded combinationally: ind_heard__ENA=1, ind_heard_meth=say_meth, ind_heard_v=say_v.
  - Nothing is written; pointers, occupancy and hiwat are unchanged; heard_count increments.
  - rule_ready also asserts in this case.
  - Zero-latency path, empty-only.
- Without it, minimum latency is 1 cycle and rule_ready never depends on say__ENA.

Test Plan:
- Reset then idle → say__RDY=1, rule_ready=0, occupancy=0, heard_count=0 for 5 cycles.
- DEPTH=4, rule_enable=0, enqueue (1,10),(2,20),(3,30),(4,40) → occupancy 1,2,3,4; hiwat rises with occupancy=3; say__RDY=0 at 4; a 5th say__ENA is ignored.
- From full, rule_enable=1, ind_heard__RDY=1 → heard (1,10),(2,20),(3,30),(4,40) on 4 consecutive cycles; heard_count=4; occupancy=0.
- Occupancy=2 with enq+deq every cycle for 10 cycles → occupancy stays 2; order preserved; pointers wrap twice without data loss.
- ind_heard__RDY=0 with occupancy=3 and rule_enable=1 → rule_ready=0, no ENA, state frozen; RDY rises → delivery resumes in order.
- Bypass build: empty FIFO, say(7,70) with rule_enable=ind_heard__RDY=1 → ind_heard__ENA=1 with (7,70) the same cycle; occupancy stays 0; heard_count=1. Non-bypass build: delivery is in the next cycle.

Source files
------------

// File: rtl/ivector_relay_if.sv
// Method-port bundle between the request decoder, the relay and the indication proxy.
// master drives say/enables and consumes the indication; slave is the relay itself.
interface ivector_relay_if #(
    parameter int METH_W = 32,
    parameter int V_W    = 32
);
    logic              say__ENA;
    logic [METH_W-1:0] say_meth;
    logic [V_W-1:0]    say_v;
    logic              say__RDY;
    logic              ind_heard__ENA;
    logic [METH_W-1:0] ind_heard_meth;
    logic [V_W-1:0]    ind_heard_v;
    logic              ind_heard__RDY;
    logic              rule_enable;
    logic              rule_ready;

    modport master (
        output say__ENA, say_meth, say_v, ind_heard__RDY, rule_enable,
        input  say__RDY, ind_heard__ENA, ind_heard_meth, ind_heard_v, rule_ready
    );

    modport slave (
        input  say__ENA, say_meth, say_v, ind_heard__RDY, rule_enable,
        output say__RDY, ind_heard__ENA, ind_heard_meth, ind_heard_v, rule_ready
    );
endinterface

// File: rtl/ivector_relay.sv
// say->heard relay: DEPTH-entry circular FIFO, dequeued by the scheduler-gated respond rule.
// Latency 1 cycle min (0 on empty when IVECTOR_RELAY_BYPASS_EN is defined); strict FIFO order.
// Backpressure: say__RDY drops only when full; ind_heard__RDY low freezes the head.
module ivector_relay #(
    parameter  int METH_W = 32,
    parameter  int V_W    = 32,
    parameter  int DEPTH  = 4,
    parameter  int HIWAT  = 3,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RST,
    ivector_relay_if.slave      bus,
    output logic [CNT_W-1:0]    occupancy,
    output logic                hiwat,
    output logic [31:0]         heard_count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [METH_W-1:0] meth;
        logic [V_W-1:0]    v;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_occ;
    logic             r_hiwat;
    logic [31:0]      r_heard_cnt;

    logic [CNT_W-1:0] w_occ_nxt;
    logic             w_empty;
    logic             w_full;
    logic             w_enq;
    logic             w_store;
    logic             w_deq;
    logic             w_byp;
    logic             w_fire;
    entry_t           w_head;

    // Full/empty come from occupancy alone; pointers are equal in both cases.
    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == CNT_W'(DEPTH));
    assign w_head  = r_mem[r_rd_ptr];

    assign bus.say__RDY = !w_full;
    assign w_enq        = bus.say__ENA & !w_full;
    assign w_deq        = bus.rule_enable & !w_empty & bus.ind_heard__RDY;

`ifdef IVECTOR_RELAY_BYPASS_EN
    // Empty FIFO with a consumer ready: hand the request straight through, store nothing.
    assign w_byp              = w_empty & bus.say__ENA & bus.rule_enable & bus.ind_heard__RDY;
    assign bus.rule_ready     = (!w_empty & bus.ind_heard__RDY) | w_byp;
    assign bus.ind_heard_meth = w_byp ? bus.say_meth : w_head.meth;
    assign bus.ind_heard_v    = w_byp ? bus.say_v    : w_head.v;
`else
    assign w_byp              = 1'b0;
    assign bus.rule_ready     = !w_empty & bus.ind_heard__RDY;
    assign bus.ind_heard_meth = w_head.meth;
    assign bus.ind_heard_v    = w_head.v;
`endif

    assign w_store            = w_enq & !w_byp;
    assign w_fire             = w_deq | w_byp;
    assign bus.ind_heard__ENA = w_fire;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_store && !w_deq) begin
            w_occ_nxt = r_occ + CNT_W'(1);
        end else if (w_deq && !w_store) begin
            w_occ_nxt = r_occ - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= '{meth: bus.say_meth, v: bus.say_v};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_occ       <= '0;
            r_hiwat     <= 1'b0;
            r_heard_cnt <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ   <= w_occ_nxt;
            // Fed from next-state occupancy so hiwat lines up with occupancy.
            r_hiwat <= (w_occ_nxt >= CNT_W'(HIWAT));
            if (w_fire && (r_heard_cnt != 32'hFFFF_FFFF)) begin
                r_heard_cnt <= r_heard_cnt + 32'd1;
            end
        end
    end

    assign occupancy   = r_occ;
    assign hiwat       = r_hiwat;
    assign heard_count = r_heard_cnt;
endmodule

// File: tb/tb_ivector_relay.sv
// Bench for ivector_relay: scoreboard monitor on every cycle plus per-scenario inline checks.
module tb_ivector_relay;
    typedef struct packed {
        logic [31:0] meth;
        logic [31:0] v;
    } word_t;

    logic        clk;
    logic        rst;
    logic [2:0]  occupancy;
    logic        hiwat;
    logic [31:0] heard_count;

    int          checks;
    int          errors;
    int          proto_errs;
    int          m_occ;
    int unsigned m_heard;
    word_t       sb_q[$];

    ivector_relay_if #(.METH_W(32), .V_W(32)) bus ();

    ivector_relay #(.METH_W(32), .V_W(32), .DEPTH(4), .HIWAT(3)) dut (
        .CLK         (clk),
        .RST         (rst),
        .bus         (bus),
        .occupancy   (occupancy),
        .hiwat       (hiwat),
        .heard_count (heard_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour evaluated mid-cycle: expected handshakes, status and delivered data.
    always @(negedge clk) begin
        logic  e_rdy;
        logic  e_byp;
        logic  e_rr;
        logic  e_ena;
        word_t got;
        word_t exp_w;
        if (rst) begin
            sb_q.delete();
            m_occ   = 0;
            m_heard = 0;
        end else begin
            e_rdy = (m_occ != 4);
            e_byp = 1'b0;
`ifdef IVECTOR_RELAY_BYPASS_EN
            e_byp = (m_occ == 0) && bus.say__ENA && bus.rule_enable && bus.ind_heard__RDY;
`endif
            e_rr  = ((m_occ != 0) && bus.ind_heard__RDY) || e_byp;
            e_ena = bus.rule_enable && e_rr;
            checks++;
            if (bus.say__RDY !== e_rdy) begin
                errors++; $display("FAIL mon_say_rdy: got %0b expected %0b at %0t", bus.say__RDY, e_rdy, $time);
            end
            checks++;
            if (bus.rule_ready !== e_rr) begin
                errors++; $display("FAIL mon_rule_ready: got %0b expected %0b at %0t", bus.rule_ready, e_rr, $time);
            end
            checks++;
            if (bus.ind_heard__ENA !== e_ena) begin
                errors++; $display("FAIL mon_ind_ena: got %0b expected %0b at %0t", bus.ind_heard__ENA, e_ena, $time);
            end
            checks++;
            if (occupancy !== 3'(m_occ)) begin
                errors++; $display("FAIL mon_occupancy: got %0d expected %0d at %0t", occupancy, m_occ, $time);
            end
            checks++;
            if (hiwat !== (m_occ >= 3)) begin
                errors++; $display("FAIL mon_hiwat: got %0b expected %0b at %0t", hiwat, (m_occ >= 3), $time);
            end
            checks++;
            if (heard_count !== m_heard) begin
                errors++; $display("FAIL mon_heard_count: got %0d expected %0d at %0t", heard_count, m_heard, $time);
            end
            if (bus.say__ENA && !e_rdy) proto_errs++;
            if (e_ena) begin
                got = '{meth: bus.ind_heard_meth, v: bus.ind_heard_v};
                if (e_byp) exp_w = '{meth: bus.say_meth, v: bus.say_v};
                else       exp_w = sb_q.pop_front();
                checks++;
                if (got !== exp_w) begin
                    errors++;
                    $display("FAIL sb_data: got (%0d,%0d) expected (%0d,%0d) at %0t",
                             got.meth, got.v, exp_w.meth, exp_w.v, $time);
                end
                m_heard++;
                if (!e_byp) m_occ--;
            end
            if (bus.say__ENA && e_rdy && !e_byp) begin
                sb_q.push_back('{meth: bus.say_meth, v: bus.say_v});
                m_occ++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.say__ENA       = 1'b0;
        bus.say_meth       = '0;
        bus.say_v          = '0;
        bus.rule_enable    = 1'b0;
        bus.ind_heard__RDY = 1'b1;
    endtask

    task automatic push_words(input int base, input int n);
        bus.rule_enable = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.say__ENA = 1'b1;
            bus.say_meth = 32'(base + i);
            bus.say_v    = 32'((base + i) * 10);
            tick();
        end
        bus.say__ENA = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.say__RDY !== 1'b1 || bus.rule_ready !== 1'b0 || occupancy !== 3'd0 || heard_count !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle: rdy=%0b rr=%0b occ=%0d cnt=%0d expected 1 0 0 0",
                         bus.say__RDY, bus.rule_ready, occupancy, heard_count);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            bus.say__ENA = 1'b1;
            bus.say_meth = 32'(i);
            bus.say_v    = 32'(i * 10);
            tick();
            bus.say__ENA = 1'b0;
            checks++;
            if (occupancy !== 3'(i) || hiwat !== (i >= 3) || bus.say__RDY !== (i < 4)) begin
                errors++;
                $display("FAIL fill_%0d: occ=%0d hiwat=%0b rdy=%0b expected %0d %0b %0b",
                         i, occupancy, hiwat, bus.say__RDY, i, (i >= 3), (i < 4));
            end
        end
        bus.say__ENA = 1'b1;
        bus.say_meth = 32'd5;
        bus.say_v    = 32'd50;
        tick();
        bus.say__ENA = 1'b0;
        checks++;
        if (occupancy !== 3'd4 || bus.say__RDY !== 1'b0 || proto_errs != 1) begin
            errors++;
            $display("FAIL fill_overflow: occ=%0d rdy=%0b proto=%0d expected 4 0 1",
                     occupancy, bus.say__RDY, proto_errs);
        end
    endtask

    task automatic test_drain();
        bus.rule_enable    = 1'b1;
        bus.ind_heard__RDY = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_meth !== 32'(i) || bus.ind_heard_v !== 32'(i * 10)) begin
                errors++;
                $display("FAIL drain_%0d: ena=%0b data=(%0d,%0d) expected 1 (%0d,%0d)",
                         i, bus.ind_heard__ENA, bus.ind_heard_meth, bus.ind_heard_v, i, i * 10);
            end
            tick();
        end
        bus.rule_enable = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || heard_count !== 32'd4) begin
            errors++; $display("FAIL drain_end: occ=%0d cnt=%0d expected 0 4", occupancy, heard_count);
        end
    endtask

    task automatic test_back_to_back();
        push_words(201, 2);
        for (int i = 0; i < 10; i++) begin
            bus.say__ENA    = 1'b1;
            bus.say_meth    = 32'(210 + i);
            bus.say_v       = 32'((210 + i) * 10);
            bus.rule_enable = 1'b1;
            tick();
            checks++;
            if (occupancy !== 3'd2) begin
                errors++; $display("FAIL b2b_occ_%0d: got %0d expected 2", i, occupancy);
            end
        end
        bus.say__ENA = 1'b0;
        tick();
        tick();
        bus.rule_enable = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || heard_count !== 32'd16) begin
            errors++; $display("FAIL b2b_end: occ=%0d cnt=%0d expected 0 16", occupancy, heard_count);
        end
    endtask

    task automatic test_backpressure();
        push_words(401, 3);
        bus.ind_heard__RDY = 1'b0;
        bus.rule_enable    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.rule_ready !== 1'b0 || bus.ind_heard__ENA !== 1'b0 || occupancy !== 3'd3 || hiwat !== 1'b1) begin
                errors++;
                $display("FAIL bp_frozen_%0d: rr=%0b ena=%0b occ=%0d hiwat=%0b expected 0 0 3 1",
                         i, bus.rule_ready, bus.ind_heard__ENA, occupancy, hiwat);
            end
            tick();
        end
        bus.ind_heard__RDY = 1'b1;
        tick();
        tick();
        tick();
        bus.rule_enable = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || heard_count !== 32'd19) begin
            errors++; $display("FAIL bp_end: occ=%0d cnt=%0d expected 0 19", occupancy, heard_count);
        end
    endtask

    task automatic test_bypass();
        bus.say__ENA       = 1'b1;
        bus.say_meth       = 32'd7;
        bus.say_v          = 32'd70;
        bus.rule_enable    = 1'b1;
        bus.ind_heard__RDY = 1'b1;
        #1;
`ifdef IVECTOR_RELAY_BYPASS_EN
        checks++;
        if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_meth !== 32'd7 || bus.ind_heard_v !== 32'd70) begin
            errors++;
            $display("FAIL bypass_same_cycle: ena=%0b data=(%0d,%0d) expected 1 (7,70)",
                     bus.ind_heard__ENA, bus.ind_heard_meth, bus.ind_heard_v);
        end
        tick();
        bus.say__ENA    = 1'b0;
        bus.rule_enable = 1'b0;
`else
        checks++;
        if (bus.ind_heard__ENA !== 1'b0 || bus.rule_ready !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same_cycle: ena=%0b rr=%0b expected 0 0", bus.ind_heard__ENA, bus.rule_ready);
        end
        tick();
        bus.say__ENA = 1'b0;
        #1;
        checks++;
        if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_meth !== 32'd7 || bus.ind_heard_v !== 32'd70) begin
            errors++;
            $display("FAIL nobypass_next_cycle: ena=%0b data=(%0d,%0d) expected 1 (7,70)",
                     bus.ind_heard__ENA, bus.ind_heard_meth, bus.ind_heard_v);
        end
        tick();
        bus.rule_enable = 1'b0;
`endif
        checks++;
        if (occupancy !== 3'd0 || heard_count !== 32'd20) begin
            errors++; $display("FAIL bypass_end: occ=%0d cnt=%0d expected 0 20", occupancy, heard_count);
        end
    endtask

    task automatic test_reset_mid();
        push_words(301, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || heard_count !== 32'd0 || bus.say__RDY !== 1'b1 || bus.rule_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: occ=%0d cnt=%0d rdy=%0b rr=%0b expected 0 0 1 0",
                     occupancy, heard_count, bus.say__RDY, bus.rule_ready);
        end
        push_words(9, 1);
        bus.rule_enable = 1'b1;
        #1;
        checks++;
        if (bus.ind_heard__ENA !== 1'b1 || bus.ind_heard_meth !== 32'd9 || bus.ind_heard_v !== 32'd90) begin
            errors++;
            $display("FAIL midreset_first: ena=%0b data=(%0d,%0d) expected 1 (9,90)",
                     bus.ind_heard__ENA, bus.ind_heard_meth, bus.ind_heard_v);
        end
        tick();
        bus.rule_enable = 1'b0;
        checks++;
        if (occupancy !== 3'd0 || heard_count !== 32'd1) begin
            errors++; $display("FAIL midreset_end: occ=%0d cnt=%0d expected 0 1", occupancy, heard_count);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        proto_errs = 0;
        m_occ      = 0;
        m_heard    = 0;
        rst        = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_backpressure();
        test_bypass();
        test_reset_mid();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
